// File: rtl/td4_seq.sv
// TD4 control unit: owns pc and carry flag, fetches from a registered ROM and
// sequences the datapath as IDLE -> FETCH -> DECODE -> EXEC, stopping on a self-jump.
module td4_seq #(
    parameter logic [3:0] RESET_PC         = 4'h0,
    parameter bit         HALT_ON_SELF_JMP = 1'b1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       run,
    input  logic       step,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic       alu_carry,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_out,
    output logic [1:0] src_sel,
    output logic [3:0] imm,
    output logic [3:0] pc,
    output logic       cflag,
    output logic       busy,
    output logic       halted
);

    localparam int unsigned PC_W  = 4;
    localparam int unsigned INS_W = 8;
    localparam int unsigned SRC_W = 2;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    localparam logic [SRC_W-1:0] SRC_A    = 2'b00;
    localparam logic [SRC_W-1:0] SRC_B    = 2'b01;
    localparam logic [SRC_W-1:0] SRC_SW   = 2'b10;
    localparam logic [SRC_W-1:0] SRC_ZERO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               cflag_q, cflag_d;
    logic [INS_W-1:0]   ir_q, ir_d;
    logic               step_q;
    logic               ld_a_q, ld_a_d;
    logic               ld_b_q, ld_b_d;
    logic               ld_out_q, ld_out_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [PC_W-1:0]    imm_q, imm_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;

    logic               step_rise_c;
    logic [PC_W-1:0]    pc_inc_c;
    logic [3:0]         op_c;
    logic [PC_W-1:0]    im_c;
    logic               halt_c;

    assign step_rise_c = step && !step_q;
    assign pc_inc_c    = PC_W'(pc_q + 4'd1);
    assign op_c        = ir_q[7:4];
    assign im_c        = ir_q[3:0];
    assign halt_c      = HALT_ON_SELF_JMP && (op_c == OP_JMP) && (im_c == pc_q);

    // Next state, pc/flag update and the control word registered for EXEC.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cflag_d  = cflag_q;
        ir_d     = ir_q;
        ld_a_d   = 1'b0;
        ld_b_d   = 1'b0;
        ld_out_d = 1'b0;
        src_d    = SRC_A;
        imm_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (run || step_rise_c) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = rom_data;
                case (rom_data[7:4])
                    OP_ADD_A:  begin ld_a_d   = 1'b1; src_d = SRC_A;    imm_d = rom_data[3:0]; end
                    OP_ADD_B:  begin ld_b_d   = 1'b1; src_d = SRC_B;    imm_d = rom_data[3:0]; end
                    OP_MOV_AI: begin ld_a_d   = 1'b1; src_d = SRC_ZERO; imm_d = rom_data[3:0]; end
                    OP_MOV_BI: begin ld_b_d   = 1'b1; src_d = SRC_ZERO; imm_d = rom_data[3:0]; end
                    OP_MOV_AB: begin ld_a_d   = 1'b1; src_d = SRC_B;    end
                    OP_MOV_BA: begin ld_b_d   = 1'b1; src_d = SRC_A;    end
                    OP_IN_A:   begin ld_a_d   = 1'b1; src_d = SRC_SW;   end
                    OP_IN_B:   begin ld_b_d   = 1'b1; src_d = SRC_SW;   end
                    OP_OUT_B:  begin ld_out_d = 1'b1; src_d = SRC_B;    end
                    OP_OUT_I:  begin ld_out_d = 1'b1; src_d = SRC_ZERO; imm_d = rom_data[3:0]; end
                    default: ;
                endcase
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_inc_c;
                cflag_d = alu_carry;
                if (op_c == OP_JMP) begin
                    pc_d    = im_c;
                    cflag_d = 1'b0;
                end else if (op_c == OP_JNC) begin
                    pc_d    = cflag_q ? pc_inc_c : im_c;
                    cflag_d = 1'b0;
                end
                if (halt_c)   state_d = S_HALT;
                else if (run) state_d = S_FETCH;
                else          state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            cflag_q  <= 1'b0;
            ir_q     <= '0;
            step_q   <= 1'b0;
            ld_a_q   <= 1'b0;
            ld_b_q   <= 1'b0;
            ld_out_q <= 1'b0;
            src_q    <= SRC_A;
            imm_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cflag_q  <= cflag_d;
            ir_q     <= ir_d;
            step_q   <= step;
            ld_a_q   <= ld_a_d;
            ld_b_q   <= ld_b_d;
            ld_out_q <= ld_out_d;
            src_q    <= src_d;
            imm_q    <= imm_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign cflag    = cflag_q;
    assign ld_a     = ld_a_q;
    assign ld_b     = ld_b_q;
    assign ld_out   = ld_out_q;
    assign src_sel  = src_q;
    assign imm      = imm_q;
    assign busy     = busy_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_td4_seq.sv
// Scoreboard bench for td4_seq: an instruction-level TD4 model predicts each EXEC
// control word and the pc/flag that follow; a monitor compares as EXEC cycles appear.
module tb_td4_seq;

    localparam logic [1:0] SRC_A    = 2'b00;
    localparam logic [1:0] SRC_B    = 2'b01;
    localparam logic [1:0] SRC_SW   = 2'b10;
    localparam logic [1:0] SRC_ZERO = 2'b11;

    logic       clk = 1'b0;
    logic       n_rst, run, step;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       alu_carry;
    logic       ld_a, ld_b, ld_out;
    logic [1:0] src_sel;
    logic [3:0] imm, pc;
    logic       cflag, busy, halted;

    always #5 clk = ~clk;

    td4_seq #(.RESET_PC(4'h0), .HALT_ON_SELF_JMP(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .run(run), .step(step),
        .rom_addr(rom_addr), .rom_data(rom_data), .alu_carry(alu_carry),
        .ld_a(ld_a), .ld_b(ld_b), .ld_out(ld_out), .src_sel(src_sel), .imm(imm),
        .pc(pc), .cflag(cflag), .busy(busy), .halted(halted)
    );

    // Environment: registered program ROM and a per-address adder carry.
    logic [7:0] rom [16];
    logic       carry_tab [16];
    assign alu_carry = carry_tab[rom_addr];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct packed {
        logic [3:0] pc;
        logic       cf;
        logic       lda;
        logic       ldb;
        logic       ldo;
        logic [1:0] src;
        logic [3:0] imm;
        logic [3:0] npc;
        logic       ncf;
        logic       halt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exec_cnt = 0;
    bit   mon_en   = 1'b0;

    logic [3:0] mpc;
    logic       mcf;
    bit         mhalt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: one call = one executed instruction.
    task automatic model_issue();
        exp_t       e;
        logic [7:0] ins;
        logic [3:0] op, im;
        ins   = rom[mpc];
        op    = ins[7:4];
        im    = ins[3:0];
        e     = '0;
        e.pc  = mpc;
        e.cf  = mcf;
        e.npc = 4'(mpc + 4'd1);
        e.ncf = carry_tab[mpc];
        case (op)
            4'h0: begin e.lda = 1'b1; e.src = SRC_A;    e.imm = im; end
            4'h5: begin e.ldb = 1'b1; e.src = SRC_B;    e.imm = im; end
            4'h3: begin e.lda = 1'b1; e.src = SRC_ZERO; e.imm = im; end
            4'h7: begin e.ldb = 1'b1; e.src = SRC_ZERO; e.imm = im; end
            4'h1: begin e.lda = 1'b1; e.src = SRC_B;    end
            4'h4: begin e.ldb = 1'b1; e.src = SRC_A;    end
            4'h2: begin e.lda = 1'b1; e.src = SRC_SW;   end
            4'h6: begin e.ldb = 1'b1; e.src = SRC_SW;   end
            4'h9: begin e.ldo = 1'b1; e.src = SRC_B;    end
            4'hB: begin e.ldo = 1'b1; e.src = SRC_ZERO; e.imm = im; end
            4'hF: begin e.npc = im; e.ncf = 1'b0; e.halt = (im == mpc); end
            4'hE: begin e.npc = mcf ? 4'(mpc + 4'd1) : im; e.ncf = 1'b0; end
            default: ;
        endcase
        q.push_back(e);
        mpc   = e.npc;
        mcf   = e.ncf;
        mhalt = e.halt;
    endtask

    // Monitor: the third consecutive busy cycle is EXEC.
    int   bcnt = 0;
    bit   post_pend = 1'b0;
    exp_t pe;
    always @(negedge clk) begin
        if (mon_en) begin
            if (post_pend) begin
                post_pend = 1'b0;
                chk("post_pc", 32'(pc), 32'(pe.npc));
                chk("post_cflag", 32'(cflag), 32'(pe.ncf));
                chk("post_halted", 32'(halted), 32'(pe.halt));
                if (pe.halt) chk("post_busy_halt", 32'(busy), 32'(0));
            end
            if (busy) bcnt++;
            else      bcnt = 0;
            if (bcnt == 3) begin
                bcnt = 0;
                exec_cnt++;
                chk("exec_expected", 32'(q.size() != 0), 32'(1));
                if (q.size() != 0) begin
                    pe = q.pop_front();
                    chk("exec_pc", 32'(pc), 32'(pe.pc));
                    chk("exec_cflag", 32'(cflag), 32'(pe.cf));
                    chk("exec_ctrl", 32'({ld_a, ld_b, ld_out, src_sel, imm}),
                        32'({pe.lda, pe.ldb, pe.ldo, pe.src, pe.imm}));
                    post_pend = 1'b1;
                end
            end else begin
                chk("idle_ctrl", 32'({ld_a, ld_b, ld_out, src_sel, imm}), 32'(0));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("rst_flags", 32'({cflag, busy, halted}), 32'(0));
        chk("rst_ctrl", 32'({ld_a, ld_b, ld_out, src_sel, imm}), 32'(0));
        n_rst  = 1'b1;
        mon_en = 1'b1;
        mpc    = 4'h0;
        mcf    = 1'b0;
        mhalt  = 1'b0;
    endtask

    task automatic drain(input int bound, output int cyc);
        cyc = 0;
        while (q.size() != 0 && cyc < bound) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        run = 1'b0;
        chk("drain_left", 32'(q.size()), 32'(0));
        q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic run_prog(input int k, output int cyc);
        for (int i = 0; i < k && !mhalt; i++) model_issue();
        run = 1'b1;
        drain(3 * k + 30, cyc);
    endtask

    task automatic step_pulse();
        step = 1'b1;
        repeat (4) @(negedge clk);
        step = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int cyc, e0;
        n_rst = 1'b0; run = 1'b0; step = 1'b0;
        for (int i = 0; i < 16; i++) begin rom[i] = 8'h80; carry_tab[i] = 1'b0; end

        // Reset held with run=1, then a short program in run mode.
        rom[0] = 8'h33; rom[1] = 8'h05; rom[2] = 8'h90;
        run = 1'b1;
        do_reset();
        run_prog(3, cyc);
        chk("run3_cycles", 32'(cyc), 32'(9));
        chk("run3_pc", 32'(pc), 32'(3));

        // ADD with carry then JNC at pc=5, with and without carry.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin rom[i] = 8'h80; carry_tab[i] = 1'b0; end
            rom[4] = 8'h01; rom[5] = 8'hE0;
            carry_tab[4] = (pass == 0);
            do_reset();
            run_prog(6, cyc);
            chk("jnc_pc", 32'(pc), (pass == 0) ? 32'(6) : 32'(0));
        end

        // Self-jump halt.
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        rom[7] = 8'hF7;
        do_reset();
        run_prog(20, cyc);
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", 32'({pc, halted, busy}), 32'({4'h7, 1'b1, 1'b0}));
            @(negedge clk);
        end
        do_reset();

        // Single step, then a second edge while busy.
        rom[0] = 8'h0A; rom[1] = 8'h53;
        e0 = exec_cnt;
        model_issue();
        step_pulse();
        drain(20, cyc);
        chk("step_one_exec", 32'(exec_cnt - e0), 32'(1));
        chk("step_one_pc", 32'(pc), 32'(1));
        e0 = exec_cnt;
        model_issue();
        step = 1'b1; @(negedge clk);
        step = 1'b0; @(negedge clk);
        step = 1'b1; repeat (2) @(negedge clk);
        step = 1'b0;
        repeat (10) @(negedge clk);
        chk("step_busy_edge_exec", 32'(exec_cnt - e0), 32'(1));
        chk("step_busy_edge_pc", 32'(pc), 32'(2));

        // Step toggling while running adds no instructions.
        e0 = exec_cnt;
        for (int i = 0; i < 6; i++) model_issue();
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin step = ~step; @(negedge clk); end
        step = 1'b0;
        drain(60, cyc);
        chk("step_in_run_exec", 32'(exec_cnt - e0), 32'(6));

        // pc wrap through 15 -> 0 on NOPs.
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        do_reset();
        run_prog(17, cyc);
        chk("wrap_pc", 32'(pc), 32'(1));

        // Reset during DECODE discards the instruction.
        rom[1] = 8'h3F;
        e0 = exec_cnt;
        step = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'(1));
        n_rst = 1'b0;
        @(negedge clk);
        step = 1'b0;
        chk("mid_rst_pc", 32'(pc), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        n_rst = 1'b1;
        mpc = 4'h0; mcf = 1'b0; mhalt = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_exec", 32'(exec_cnt - e0), 32'(0));

        // Random programs, run mode then a few single steps.
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 16; i++) begin
                rom[i]       = 8'($urandom);
                carry_tab[i] = 1'($urandom);
            end
            do_reset();
            run_prog(int'($urandom_range(4, 24)), cyc);
            for (int s = 0; s < 2 && !mhalt; s++) begin
                model_issue();
                step_pulse();
                drain(20, cyc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
